// File: rtl/beat_player.sv
// Drum-machine datapath: stores four 8-step patterns and the tempo, derives the
// eighth-note step tick, and emits per-instrument trigger pulses and a step LED.
module beat_player #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned TRIG_CYCLES = 2500000,
  parameter int unsigned BPM_DEFAULT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       ld_ins1,
  input  logic       ld_ins2,
  input  logic       ld_ins3,
  input  logic       ld_ins4,
  input  logic       ld_bpm,
  input  logic       play,
  input  logic [3:0] timing,
  output logic       step_tick,
  output logic [3:0] trig,
  output logic [7:0] active_step,
  output logic       bpm_err
);

  localparam logic [63:0]      TICK_DIV_W = 64'(CLK_HZ) * 64'd30;
  localparam logic [ACC_W-1:0] TICK_DIV   = ACC_W'(TICK_DIV_W);
  localparam int unsigned      CNT_W      = $clog2(TRIG_CYCLES + 1);
  localparam logic [CNT_W-1:0] TRIG_LOAD  = CNT_W'(TRIG_CYCLES);
  localparam logic [7:0]       BPM_RST    = 8'(BPM_DEFAULT);

  logic [3:0][7:0]       r_pat;
  logic [7:0]            r_bpm;
  logic                  r_bpm_err;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_tick;
  logic [3:0]            r_s1;
  logic [3:0]            r_s2;
  logic [3:0]            r_prev;
  logic [3:0][CNT_W-1:0] r_cnt;
  logic [3:0]            r_trig;
  logic [7:0]            r_act;

  logic [3:0]            w_ld;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_wrap;
  logic                  w_valid;
  logic                  w_event;
  logic [2:0]            w_idx;
  logic [7:0]            w_onehot;
  logic [3:0][CNT_W-1:0] w_cnt_next;
  logic [3:0]            w_trig_next;

  assign w_ld     = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};
  assign w_sum    = r_acc + ACC_W'(r_bpm);
  assign w_wrap   = (w_sum >= TICK_DIV);
  assign w_valid  = (r_s2 >= 4'd1) && (r_s2 <= 4'd8);
  assign w_event  = play && w_valid && (r_s2 != r_prev);
  assign w_idx    = 3'(r_s2 - 4'd1);
  assign w_onehot = 8'b1 << w_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pat     <= '0;
      r_bpm     <= BPM_RST;
      r_bpm_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_ld[i]) r_pat[i] <= data_in;
      end
      if (ld_bpm) begin
        if (data_in == '0) begin
          r_bpm_err <= 1'b1;
        end else begin
          r_bpm     <= data_in;
          r_bpm_err <= 1'b0;
        end
      end
    end
  end

  // Remainder is carried across ticks so the average period is exact.
  always_ff @(posedge clk) begin
    if (!reset || !play) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_acc  <= w_sum - TICK_DIV;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= timing;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // trig is registered from the counter's next value so it rises on the event edge.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_trig_next = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!play) begin
        w_cnt_next[i] = '0;
      end else if (w_event && r_pat[i][w_idx]) begin
        w_cnt_next[i] = TRIG_LOAD;
      end else if (r_cnt[i] != '0) begin
        w_cnt_next[i] = r_cnt[i] - CNT_W'(1);
      end
      w_trig_next[i] = (w_cnt_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_trig <= '0;
      r_act  <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_trig <= w_trig_next;
      r_act  <= (play && w_valid) ? w_onehot : '0;
    end
  end

  assign step_tick   = r_tick;
  assign trig        = r_trig;
  assign active_step = r_act;
  assign bpm_err     = r_bpm_err;

endmodule

// File: tb/tb_beat_player.sv
// Self-checking bench for beat_player: a cycle model built from cumulative tempo
// sums and a timing-sample history, plus directed literal expectations.
module tb_beat_player;

  localparam int TD   = 3000;
  localparam int TRIG = 4;

  logic       clk = 1'b0;
  logic       reset, ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm, play;
  logic [7:0] data_in;
  logic [3:0] timing;
  logic       step_tick, bpm_err;
  logic [3:0] trig;
  logic [7:0] active_step;

  int checks = 0;
  int errors = 0;

  beat_player #(.CLK_HZ(100), .ACC_W(32), .TRIG_CYCLES(TRIG), .BPM_DEFAULT(120)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .ld_ins1(ld_ins1), .ld_ins2(ld_ins2), .ld_ins3(ld_ins3), .ld_ins4(ld_ins4),
    .ld_bpm(ld_bpm), .play(play), .timing(timing),
    .step_tick(step_tick), .trig(trig), .active_step(active_step), .bpm_err(bpm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         edge_n = 0;
  int         rst_edge = 0;
  logic [3:0] samp[$];
  logic [7:0] m_pat[4];
  int         m_bpm;
  logic       m_err;
  longint     m_sum;
  int         last_fire[4] = '{-1, -1, -1, -1};
  int         last_kill = 0;
  bit         m_valid = 0;
  logic       e_tick;
  logic [3:0] e_trig;
  logic [7:0] e_act;

  // Synchronised timing value seen at edge n: the sample from two edges earlier,
  // or 0 if a reset edge lies in between.
  function automatic int s2_at(input int n);
    if (n - 2 >= 0 && n - 2 > rst_edge) return int'(samp[n-2]);
    return 0;
  endfunction

  function automatic int prev_at(input int n);
    if (n - 1 > rst_edge) return s2_at(n - 1);
    return 0;
  endfunction

  always @(posedge clk) begin
    int  k, kp;
    bit  ev;
    longint s_new;
    samp.push_back(timing);
    if (reset === 1'b0) begin
      rst_edge  = edge_n;
      last_kill = edge_n;
      for (int i = 0; i < 4; i++) m_pat[i] = '0;
      m_bpm   = 120;
      m_err   = 1'b0;
      m_sum   = 0;
      e_tick  = 1'b0;
      e_trig  = '0;
      e_act   = '0;
      m_valid = 1;
    end else begin
      k  = s2_at(edge_n);
      kp = prev_at(edge_n);
      ev = play && (k != kp) && (k >= 1) && (k <= 8);
      if (!play) begin
        m_sum     = 0;
        last_kill = edge_n;
        e_tick    = 1'b0;
      end else begin
        s_new  = m_sum + m_bpm;
        e_tick = (s_new / TD) != (m_sum / TD);
        m_sum  = s_new;
      end
      for (int i = 0; i < 4; i++) begin
        if (ev && m_pat[i][k-1]) last_fire[i] = edge_n;
        e_trig[i] = (last_fire[i] > last_kill) && (edge_n - last_fire[i] < TRIG);
      end
      e_act = (play && k >= 1 && k <= 8) ? (8'b1 << (k - 1)) : 8'h00;
      if (ld_ins1) m_pat[0] = data_in;
      if (ld_ins2) m_pat[1] = data_in;
      if (ld_ins3) m_pat[2] = data_in;
      if (ld_ins4) m_pat[3] = data_in;
      if (ld_bpm) begin
        if (data_in == 0) m_err = 1'b1;
        else begin m_bpm = int'(data_in); m_err = 1'b0; end
      end
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_step_tick", 32'(step_tick), 32'(e_tick));
      chk("model_trig", 32'(trig), 32'(e_trig));
      chk("model_active_step", 32'(active_step), 32'(e_act));
      chk("model_bpm_err", 32'(bpm_err), 32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_tick(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (step_tick !== 1'b1 && gap < limit);
    if (step_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no step_tick within %0d cycles", limit);
    end
  endtask

  task automatic load(input int which, input logic [7:0] v);
    data_in = v;
    case (which)
      1: ld_ins1 = 1'b1;
      2: ld_ins2 = 1'b1;
      3: ld_ins3 = 1'b1;
      4: ld_ins4 = 1'b1;
      default: ld_bpm = 1'b1;
    endcase
    @(negedge clk);
    {ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm} = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, tot;
    reset = 1'b0; play = 1'b0; data_in = '0; timing = '0;
    {ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm} = '0;
    repeat (3) @(negedge clk);
    chk("rst_step_tick", 32'(step_tick), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_active_step", 32'(active_step), 32'd0);
    chk("rst_bpm_err", 32'(bpm_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // tempo at default 120 bpm
    play = 1'b1;
    wait_tick(100, g);
    chk("first_tick_120", 32'(g), 32'd25);
    repeat (2) begin
      wait_tick(100, g);
      chk("gap_120", 32'(g), 32'd25);
    end

    // bpm load errors and tempo changes
    load(0, 8'd0);
    chk("bpm_err_zero", 32'(bpm_err), 32'd1);
    wait_tick(100, g);
    wait_tick(100, g);
    chk("gap_120_after_err", 32'(g), 32'd25);
    load(0, 8'd200);
    chk("bpm_err_clear", 32'(bpm_err), 32'd0);
    wait_tick(100, g);
    repeat (2) begin
      wait_tick(100, g);
      chk("gap_200", 32'(g), 32'd15);
    end
    load(0, 8'd7);
    wait_tick(1000, g);
    tot = 0;
    repeat (7) begin
      wait_tick(1000, g);
      chk("gap_7_range", 32'(g == 428 || g == 429), 32'd1);
      tot += g;
    end
    chk("gap_7_sum", 32'(tot), 32'd3000);

    // single-step trigger on instrument 1
    load(1, 8'b0000_0101);
    timing = 4'd1;
    @(negedge clk); chk("trig0_lat1", 32'(trig[0]), 32'd0);
    @(negedge clk); chk("trig0_lat2", 32'(trig[0]), 32'd0);
    @(negedge clk);
    chk("trig_step1", 32'(trig), 32'b0001);
    chk("active_step1", 32'(active_step), 32'h01);
    repeat (3) begin
      @(negedge clk); chk("trig0_hold", 32'(trig[0]), 32'd1);
    end
    @(negedge clk); chk("trig0_end", 32'(trig[0]), 32'd0);
    timing = 4'd2;
    repeat (3) @(negedge clk);
    chk("active_step2", 32'(active_step), 32'h02);
    chk("trig0_step2", 32'(trig[0]), 32'd0);
    timing = 4'd3;
    repeat (3) @(negedge clk);
    chk("trig0_step3", 32'(trig[0]), 32'd1);
    chk("active_step3", 32'(active_step), 32'h04);

    // back-to-back retriggers on instrument 2
    load(2, 8'b0000_0011);
    timing = 4'd1;
    @(negedge clk); timing = 4'd2;
    @(negedge clk); timing = 4'd1;
    @(negedge clk); chk("trig1_start", 32'(trig[1]), 32'd1);
    repeat (5) begin
      @(negedge clk); chk("trig1_continuous", 32'(trig[1]), 32'd1);
    end
    @(negedge clk); chk("trig1_end", 32'(trig[1]), 32'd0);

    // play drop kills pulses; invalid timing gives no event
    load(3, 8'hFF);
    timing = 4'd4;
    repeat (3) @(negedge clk);
    chk("trig2_on", 32'(trig[2]), 32'd1);
    play = 1'b0;
    @(negedge clk);
    chk("stop_trig", 32'(trig), 32'd0);
    chk("stop_active", 32'(active_step), 32'd0);
    chk("stop_tick", 32'(step_tick), 32'd0);
    timing = 4'd9;
    load(0, 8'd120);
    repeat (3) @(negedge clk);
    play = 1'b1;
    wait_tick(100, g);
    chk("restart_first_tick", 32'(g), 32'd25);
    chk("timing9_trig", 32'(trig), 32'd0);
    chk("timing9_active", 32'(active_step), 32'd0);

    // reset mid-pulse overrides a simultaneous load
    load(0, 8'd200);
    load(0, 8'd0);
    load(4, 8'hFF);
    timing = 4'd5;
    repeat (3) @(negedge clk);
    chk("trig3_on", 32'(trig[3]), 32'd1);
    reset = 1'b0; ld_ins4 = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    chk("mid_rst_trig", 32'(trig), 32'd0);
    chk("mid_rst_bpm_err", 32'(bpm_err), 32'd0);
    chk("mid_rst_active", 32'(active_step), 32'd0);
    chk("mid_rst_tick", 32'(step_tick), 32'd0);
    reset = 1'b1; ld_ins4 = 1'b0;
    wait_tick(100, g);
    chk("post_rst_tick_120", 32'(g), 32'd25);
    chk("post_rst_trig", 32'(trig), 32'd0);
    chk("post_rst_active", 32'(active_step), 32'h10);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
